// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
package mbist_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned NumElem = 6;

  typedef logic [2:0] elem_t;

  localparam elem_t LastElem = elem_t'(NumElem - 1);

  typedef struct packed {
    logic down;    // address order N-1..0
    logic has_rd;
    logic rd_pol;  // 1 = expect ~background
    logic has_wr;
    logic wr_pol;  // 1 = write ~background
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(input elem_t elem);
    elem_cfg_t cfg;
    case (elem)
      3'd0:    cfg = '{down: 1'b0, has_rd: 1'b0, rd_pol: 1'b0, has_wr: 1'b1, wr_pol: 1'b0};
      3'd1:    cfg = '{down: 1'b0, has_rd: 1'b1, rd_pol: 1'b0, has_wr: 1'b1, wr_pol: 1'b1};
      3'd2:    cfg = '{down: 1'b0, has_rd: 1'b1, rd_pol: 1'b1, has_wr: 1'b1, wr_pol: 1'b0};
      3'd3:    cfg = '{down: 1'b1, has_rd: 1'b1, rd_pol: 1'b0, has_wr: 1'b1, wr_pol: 1'b1};
      3'd4:    cfg = '{down: 1'b1, has_rd: 1'b1, rd_pol: 1'b1, has_wr: 1'b1, wr_pol: 1'b0};
      3'd5:    cfg = '{down: 1'b1, has_rd: 1'b1, rd_pol: 1'b0, has_wr: 1'b0, wr_pol: 1'b0};
      default: cfg = '0;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/mbist_rd_cmp.sv
// Read-compare pipe: delays {expected, addr, elem} by RD_LAT cycles, compares
// against returning read data and captures the first mismatch.
module mbist_rd_cmp
  import mbist_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              req_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  elem_t             elem_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o,
  output elem_t             fail_elem_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] exp_q  [RD_LAT];
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  elem_t             elem_q [RD_LAT];

  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  elem_t             fail_elem_q;
  logic              mis;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_q[i]  <= '0;
        addr_q[i] <= '0;
        elem_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= req_i & ~clr_i;
      exp_q[0]  <= exp_i;
      addr_q[0] <= addr_i;
      elem_q[0] <= elem_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1] & ~clr_i;
        exp_q[i]  <= exp_q[i-1];
        addr_q[i] <= addr_q[i-1];
        elem_q[i] <= elem_q[i-1];
      end
    end
  end

  assign mis = vld_q[RD_LAT-1] && (rdata_i != exp_q[RD_LAT-1]);

  // Only the first mismatch of a run is kept; later ones are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
    end else if (clr_i) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
    end else if (mis && !fail_q) begin
      fail_q      <= 1'b1;
      fail_addr_q <= addr_q[RD_LAT-1];
      fail_data_q <= rdata_i;
      fail_elem_q <= elem_q[RD_LAT-1];
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign fail_elem_o = fail_elem_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer: one memory access per RUN cycle, then an RD_LAT
// drain so the last read is compared before done is raised.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] background,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem
);

  localparam logic [ADDR_W-1:0] FirstAddr = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LastAddr  = {ADDR_W{1'b1}};
  localparam logic [1:0]        DrainInit = 2'(RD_LAT - 1);

  state_e            state_q;
  logic [DATA_W-1:0] bg_q;
  elem_t             seq_elem_q;
  logic [ADDR_W-1:0] seq_addr_q;
  logic              seq_rd_q;
  logic              last_q;
  logic [1:0]        drain_q;
  logic              busy_q, done_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, mem_exp_q;
  elem_t             mem_elem_q;

  logic              start_acc, do_issue;
  elem_t             iss_elem, elem_inc;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_rd;
  logic [DATA_W-1:0] iss_bg, iss_wdata, iss_exp;
  elem_cfg_t         cfg, nxt_cfg;
  elem_t             nxt_elem_d;
  logic [ADDR_W-1:0] nxt_addr_d;
  logic              nxt_rd_d, nxt_last_d;

  // On an accepted start the first access (E0 w0 @0) is issued in the same edge.
  always_comb begin
    start_acc = start && (state_q == StIdle || state_q == StDone);
    do_issue  = start_acc || (state_q == StRun && !last_q);
    iss_elem  = start_acc ? '0 : seq_elem_q;
    iss_addr  = start_acc ? FirstAddr : seq_addr_q;
    iss_rd    = start_acc ? 1'b0 : seq_rd_q;
    iss_bg    = start_acc ? background : bg_q;
    elem_inc  = iss_elem + 3'd1;
    cfg       = elem_cfg(iss_elem);
    nxt_cfg   = elem_cfg(elem_inc);
    iss_wdata = cfg.wr_pol ? ~iss_bg : iss_bg;
    iss_exp   = cfg.rd_pol ? ~iss_bg : iss_bg;

    nxt_elem_d = iss_elem;
    nxt_addr_d = iss_addr;
    nxt_rd_d   = 1'b0;
    nxt_last_d = 1'b0;
    if (iss_rd && cfg.has_wr) begin
      nxt_rd_d = 1'b0;
    end else if (iss_addr == (cfg.down ? FirstAddr : LastAddr)) begin
      if (iss_elem == LastElem) begin
        nxt_last_d = 1'b1;
      end else begin
        nxt_elem_d = elem_inc;
        nxt_addr_d = nxt_cfg.down ? LastAddr : FirstAddr;
        nxt_rd_d   = nxt_cfg.has_rd;
      end
    end else begin
      nxt_addr_d = cfg.down ? iss_addr - ADDR_W'(1) : iss_addr + ADDR_W'(1);
      nxt_rd_d   = cfg.has_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      bg_q        <= '0;
      seq_elem_q  <= '0;
      seq_addr_q  <= '0;
      seq_rd_q    <= 1'b0;
      last_q      <= 1'b0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_exp_q   <= '0;
      mem_elem_q  <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_acc) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            bg_q    <= background;
          end
        end
        StRun: begin
          if (last_q) begin
            state_q  <= StDrain;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            last_q   <= 1'b0;
            drain_q  <= DrainInit;
          end
        end
        StDrain: begin
          if (drain_q == 2'd0) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (do_issue) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= ~iss_rd;
        mem_addr_q  <= iss_addr;
        mem_wdata_q <= iss_wdata;
        mem_exp_q   <= iss_exp;
        mem_elem_q  <= iss_elem;
        seq_elem_q  <= nxt_elem_d;
        seq_addr_q  <= nxt_addr_d;
        seq_rd_q    <= nxt_rd_d;
        last_q      <= nxt_last_d;
      end
    end
  end

  mbist_rd_cmp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_cmp (
    .clk_i       (clk),
    .rst_ni      (reset),
    .clr_i       (start_acc),
    .req_i       (mem_en_q & ~mem_we_q),
    .exp_i       (mem_exp_q),
    .addr_i      (mem_addr_q),
    .elem_i      (mem_elem_q),
    .rdata_i     (mem_rdata),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_data_o (fail_data),
    .fail_elem_o (fail_elem)
  );

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench: RD_LAT=1 and RD_LAT=3 controllers, each on a behavioural
// memory with an optional stuck-at-1 fault.
module tb_mbist_march_ctrl;

  localparam int N = 16;
  // March C- table, bit e = element e
  localparam logic [5:0] DN   = 6'b111000;
  localparam logic [5:0] HRD  = 6'b111110;
  localparam logic [5:0] HWR  = 6'b011111;
  localparam logic [5:0] WPOL = 6'b001010;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct {
    int         cyc;
    logic       fail;
    logic [3:0] addr;
    logic [7:0] data;
    logic [2:0] elem;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start1, start3;
  logic [7:0] bg;
  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  acc_t acc_q[$];
  res_t dq1[$];
  res_t dq3[$];

  logic       mem_en1, mem_we1, busy1, done1, fail1;
  logic [3:0] mem_addr1, fail_addr1;
  logic [7:0] mem_wdata1, mem_rdata1, fail_data1;
  logic [2:0] fail_elem1;
  logic       mem_en3, mem_we3, busy3, done3, fail3;
  logic [3:0] mem_addr3, fail_addr3;
  logic [7:0] mem_wdata3, mem_rdata3, fail_data3;
  logic [2:0] fail_elem3;

  logic [7:0] mem1 [N];
  logic [7:0] mem3 [N];
  logic [7:0] rd1_q;
  logic [7:0] rd3_q [3];
  logic [3:0] f1_addr, f3_addr;
  logic [7:0] f1_mask, f3_mask;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mbist_march_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .background(bg),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1), .done(done1), .fail(fail1),
    .fail_addr(fail_addr1), .fail_data(fail_data1), .fail_elem(fail_elem1)
  );

  mbist_march_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .background(bg),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .done(done3), .fail(fail3),
    .fail_addr(fail_addr3), .fail_data(fail_data3), .fail_elem(fail_elem3)
  );

  always @(posedge clk) begin
    if (mem_en1) begin
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
      else rd1_q <= mem1[mem_addr1] | ((mem_addr1 == f1_addr) ? f1_mask : 8'h00);
    end
  end
  assign mem_rdata1 = rd1_q;

  always @(posedge clk) begin
    if (mem_en3) begin
      if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
      else rd3_q[0] <= mem3[mem_addr3] | ((mem_addr3 == f3_addr) ? f3_mask : 8'h00);
    end
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign mem_rdata3 = rd3_q[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero1(input string tag);
    chk({tag, "_mem_en"}, mem_en1, 0);
    chk({tag, "_mem_we"}, mem_we1, 0);
    chk({tag, "_mem_addr"}, mem_addr1, 0);
    chk({tag, "_mem_wdata"}, mem_wdata1, 0);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_fail"}, fail1, 0);
    chk({tag, "_fail_addr"}, fail_addr1, 0);
    chk({tag, "_fail_data"}, fail_data1, 0);
    chk({tag, "_fail_elem"}, fail_elem1, 0);
  endtask

  task automatic push_march(input logic [7:0] b);
    logic [3:0] a;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = DN[e] ? 4'(N - 1 - k) : 4'(k);
        if (HRD[e]) acc_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
        if (HWR[e]) acc_q.push_back('{we: 1'b1, addr: a, data: WPOL[e] ? ~b : b});
      end
    end
  endtask

  // lat selects the instance (1 or 3); done expected 10N+lat after the start edge
  task automatic launch(input int lat, input logic [7:0] b, input logic f,
                        input logic [3:0] fa, input logic [7:0] fd, input logic [2:0] fe);
    res_t r;
    @(negedge clk);
    bg = b;
    r.cyc = cyc + 1 + 10 * N + lat;
    r.fail = f;
    r.addr = fa;
    r.data = fd;
    r.elem = fe;
    if (lat == 1) begin
      start1 = 1'b1;
      dq1.push_back(r);
      push_march(b);
    end else begin
      start3 = 1'b1;
      dq3.push_back(r);
    end
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int lat);
    int i;
    i = 0;
    while (i < 400 && !((lat == 1) ? done1 : done3)) begin
      @(negedge clk);
      i++;
    end
    chk("done_timeout", (lat == 1) ? done1 : done3, 1);
  endtask

  // Monitor: pops expected accesses and end-of-run results as the DUTs present them.
  initial begin
    logic p1, p3;
    acc_t a;
    res_t r;
    p1 = 1'b0;
    p3 = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_en1) begin
          chk("acc_pending", acc_q.size() > 0, 1);
          if (acc_q.size() > 0) begin
            a = acc_q.pop_front();
            chk("acc_we", mem_we1, a.we);
            chk("acc_addr", mem_addr1, a.addr);
            if (a.we) chk("acc_wdata", mem_wdata1, a.data);
            chk("busy_run", busy1, 1);
          end
        end
        if (done1 && !p1) begin
          chk("done1_pending", dq1.size() > 0, 1);
          if (dq1.size() > 0) begin
            r = dq1.pop_front();
            chk("done1_cycle", cyc, r.cyc);
            chk("done1_busy", busy1, 0);
            chk("done1_fail", fail1, r.fail);
            chk("done1_fail_addr", fail_addr1, r.addr);
            chk("done1_fail_data", fail_data1, r.data);
            chk("done1_fail_elem", fail_elem1, r.elem);
          end
        end
        if (done3 && !p3) begin
          chk("done3_pending", dq3.size() > 0, 1);
          if (dq3.size() > 0) begin
            r = dq3.pop_front();
            chk("done3_cycle", cyc, r.cyc);
            chk("done3_busy", busy3, 0);
            chk("done3_fail", fail3, r.fail);
            chk("done3_fail_addr", fail_addr3, r.addr);
            chk("done3_fail_data", fail_data3, r.data);
            chk("done3_fail_elem", fail_elem3, r.elem);
          end
        end
      end
      p1 = done1;
      p3 = done3;
    end
  end

  initial begin
    start1 = 1'b0;
    start3 = 1'b0;
    bg = 8'h00;
    f1_addr = 4'd0;
    f1_mask = 8'h00;
    f3_addr = 4'd0;
    f3_mask = 8'h00;
    #3;
    check_zero1("por");
    chk("por_busy3", busy3, 0);
    chk("por_done3", done3, 0);
    @(negedge clk);
    reset = 1'b1;

    // fault-free, background 00, with a start pulse mid-run that must be ignored
    launch(1, 8'h00, 1'b0, 4'd0, 8'h00, 3'd0);
    repeat (19) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1);

    // stuck-at-1 on bit 3 of address 5: first seen by the E1 r0
    f1_addr = 4'd5;
    f1_mask = 8'h08;
    launch(1, 8'h00, 1'b1, 4'd5, 8'h08, 3'd1);
    wait_done(1);

    // start from DONE clears done and the failure capture
    f1_mask = 8'h00;
    launch(1, 8'h00, 1'b0, 4'd0, 8'h00, 3'd0);
    chk("restart_done", done1, 0);
    chk("restart_fail", fail1, 0);
    chk("restart_fail_addr", fail_addr1, 0);
    chk("restart_fail_data", fail_data1, 0);
    chk("restart_fail_elem", fail_elem1, 0);
    wait_done(1);

    launch(1, 8'hA5, 1'b0, 4'd0, 8'h00, 3'd0);
    wait_done(1);

    // asynchronous abort around run cycle 50
    launch(1, 8'h00, 1'b0, 4'd0, 8'h00, 3'd0);
    repeat (48) @(negedge clk);
    chk("pre_abort_busy", busy1, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    acc_q.delete();
    dq1.delete();
    check_zero1("abort");
    @(negedge clk);
    reset = 1'b1;
    launch(1, 8'h00, 1'b0, 4'd0, 8'h00, 3'd0);
    wait_done(1);

    // RD_LAT=3, stuck-at-1 on bit 0 of address 15
    f3_addr = 4'd15;
    f3_mask = 8'h01;
    launch(3, 8'h00, 1'b1, 4'd15, 8'h01, 3'd1);
    wait_done(3);

    @(negedge clk);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("dq1_drained", dq1.size(), 0);
    chk("dq3_drained", dq3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
